// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - boot-time byte-stream loader for the instruction memory write port.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOAD_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  input  logic                  reload_req,
  output logic                  im_we,
  output logic [ADDR_WIDTH-1:0] im_waddr,
  output logic [ADDR_WIDTH-1:0] im_wdata,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  err
);

`ifdef IMEM_LOAD_CHECKSUM_EN
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;
  localparam state_t FIN = CSUM;
`else
  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, DONE, ERR} state_t;
  localparam state_t FIN = DONE;
`endif

  localparam logic [15:0] MEM_WORDS = 16'(MEM_SIZE);

  state_t      state, state_nxt;
  logic [15:0] len;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_q;
  logic        xfer;
  logic [15:0] len_full;
  logic        last_word;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  // Handshake depends on state only, never on rx_valid.
  assign rx_ready  = (state != DONE) && (state != ERR);
  assign busy      = rx_ready;
  assign err       = (state == ERR);
  assign xfer      = rx_valid && rx_ready;
  assign len_full  = {rx_data, len[7:0]};
  assign last_word = ((word_idx + 16'd1) == len);

  always_comb begin
    state_nxt = state;
    case (state)
      LEN_LO: if (xfer) state_nxt = LEN_HI;
      LEN_HI: begin
        if (xfer) begin
          if (len_full == 16'd0)          state_nxt = FIN;
          else if (len_full > MEM_WORDS)  state_nxt = ERR;
          else                            state_nxt = DATA;
        end
      end
      DATA: if (xfer && (byte_cnt == 2'd3) && last_word) state_nxt = FIN;
`ifdef IMEM_LOAD_CHECKSUM_EN
      CSUM: if (xfer) state_nxt = (rx_data == csum) ? DONE : ERR;
`endif
      DONE, ERR: if (reload_req) state_nxt = LEN_LO;
      default: state_nxt = LEN_LO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LEN_LO;
      im_we     <= 1'b0;
      im_waddr  <= '0;
      im_wdata  <= '0;
      cpu_rst_n <= 1'b0;
      len       <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      asm_q     <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state     <= state_nxt;
      im_we     <= 1'b0;
      // One cycle of DONE before release lets the final IM write land first.
      cpu_rst_n <= (state == DONE) && !reload_req;
      case (state)
        LEN_LO: if (xfer) len[7:0] <= rx_data;
        LEN_HI: begin
          if (xfer) begin
            len[15:8] <= rx_data;
            word_idx  <= '0;
            byte_cnt  <= '0;
          end
        end
        DATA: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum     <= csum ^ rx_data;
`endif
            case (byte_cnt)
              2'd0: asm_q[7:0]   <= rx_data;
              2'd1: asm_q[15:8]  <= rx_data;
              2'd2: asm_q[23:16] <= rx_data;
              default: begin
                im_we    <= 1'b1;
                im_waddr <= ADDR_WIDTH'({word_idx, 2'b00});
                im_wdata <= ADDR_WIDTH'({rx_data, asm_q});
                word_idx <= word_idx + 16'd1;
              end
            endcase
          end
        end
        DONE, ERR: begin
          if (reload_req) begin
            len      <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            asm_q    <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - scoreboard bench for imem_boot_loader against a stream-level reference model.
module tb_imem_boot_loader;
  localparam int MEM_SIZE = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        reload_req;
  logic        im_we;
  logic [31:0] im_waddr;
  logic [31:0] im_wdata;
  logic        cpu_rst_n;
  logic        busy;
  logic        err;

  imem_boot_loader #(.ADDR_WIDTH(32), .MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .reload_req(reload_req), .im_we(im_we), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  wr_t         exp_q[$];
  wr_t         mon_w;
  logic [7:0]  stream[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && im_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_im_we: got addr %h data %h expected no write", im_waddr, im_wdata);
        end else begin
          mon_w = exp_q.pop_front();
          check("im_waddr", im_waddr, mon_w.addr);
          check("im_wdata", im_wdata, mon_w.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    check("rx_ready", rx_ready, 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic make_random(input int len);
    stream.delete();
    stream.push_back(8'(len));
    stream.push_back(8'(len >> 8));
    if (len <= MEM_SIZE)
      for (int i = 0; i < 4 * len; i++) stream.push_back(8'($urandom));
  endtask

  // Reference: length prefix, little-endian words at consecutive word addresses.
  task automatic run_stream(input int gap_max, input bit use_model, input bit corrupt);
    int         len;
    bit         exp_err;
    logic [7:0] x;
    len     = {stream[1], stream[0]};
    exp_err = (len > MEM_SIZE);
    if (use_model && !exp_err)
      for (int i = 0; i < len; i++)
        exp_q.push_back('{32'(i * 4), {stream[2+4*i+3], stream[2+4*i+2], stream[2+4*i+1], stream[2+4*i]}});
`ifdef IMEM_LOAD_CHECKSUM_EN
    if (!exp_err) begin
      x = 8'h00;
      for (int k = 2; k < stream.size(); k++) x ^= stream[k];
      stream.push_back(corrupt ? (x ^ 8'h5A) : x);
      exp_err = corrupt;
    end
`else
    x = {7'd0, corrupt};
`endif
    foreach (stream[k]) send_byte(stream[k], $urandom_range(0, gap_max));
    check("busy_end", busy, 0);
    check("cpu_rst_n_entry", cpu_rst_n, 0);
    @(negedge clk);
    check("cpu_rst_n_final", cpu_rst_n, {31'd0, !exp_err});
    check("err_final", err, {31'd0, exp_err});
    check("rx_ready_final", rx_ready, 0);
    check("pending_writes", exp_q.size(), 0);
  endtask

  task automatic reload();
    reload_req = 1'b1;
    @(negedge clk);
    reload_req = 1'b0;
    check("reload_cpu_rst_n", cpu_rst_n, 0);
    check("reload_busy", busy, 1);
    check("reload_err", err, 0);
    check("reload_rx_ready", rx_ready, 1);
  endtask

  task automatic nominal(input int gap_max);
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    exp_q.push_back('{32'h0, 32'h00500013});
    exp_q.push_back('{32'h4, 32'h00A00093});
    run_stream(gap_max, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n      = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    reload_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_im_we", im_we, 0);
    check("rst_cpu_rst_n", cpu_rst_n, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 1);
    rst_n = 1'b1;
    @(negedge clk);

    nominal(0);
    reload();
    nominal(3);
    reload();

    stream = '{8'h41, 8'h00};
    run_stream(0, 1'b1, 1'b0);
    reload();
    stream = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    exp_q.push_back('{32'h0, 32'hDEADBEEF});
    run_stream(1, 1'b0, 1'b0);
    reload();

    stream = '{8'h00, 8'h01};
    run_stream(0, 1'b1, 1'b0);
    reload();
    stream = '{8'h00, 8'h00};
    run_stream(0, 1'b1, 1'b0);
    reload();

    make_random(MEM_SIZE);
    run_stream(0, 1'b1, 1'b0);
    reload();
    for (int it = 0; it < 6; it++) begin
      make_random($urandom_range(1, 8));
      run_stream(2, 1'b1, 1'b0);
      reload();
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    make_random(3);
    run_stream(1, 1'b1, 1'b1);
    reload();
`endif

    stream = '{8'h02, 8'h00, 8'h13, 8'h00};
    foreach (stream[k]) send_byte(stream[k], 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_im_we", im_we, 0);
    check("mid_rst_im_waddr", im_waddr, 0);
    check("mid_rst_im_wdata", im_wdata, 0);
    check("mid_rst_cpu_rst_n", cpu_rst_n, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_rx_ready", rx_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    nominal(1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
